// File: rtl/buf_mux_sequencer.sv
// buf_mux_sequencer: ping-pong line buffer RGB mux sequencer with valid/ready byte output
module buf_mux_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int LINE_PIXELS = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              buf_full1,
  input  logic              buf_full2,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sel_r1,
  output logic              sel_g1,
  output logic              sel_b1,
  output logic              sel_r2,
  output logic              sel_g2,
  output logic              sel_b2,
  output logic              buf_sel,
  output logic              out_valid,
  output logic              buf_done1,
  output logic              buf_done2,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, WAIT_BUF, SEND_R, SEND_G, SEND_B} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_PIXELS - 1);
  state_t     state;
  logic [2:0] sel;
  logic       adv;
  logic       full;
  assign adv     = !out_valid || out_ready;
  assign full    = buf_sel ? buf_full2 : buf_full1;
  assign busy    = state != IDLE;
  assign sel_r1  = sel[0] & ~buf_sel;
  assign sel_g1  = sel[1] & ~buf_sel;
  assign sel_b1  = sel[2] & ~buf_sel;
  assign sel_r2  = sel[0] & buf_sel;
  assign sel_g2  = sel[1] & buf_sel;
  assign sel_b2  = sel[2] & buf_sel;
  // Sequencer: WAIT_BUF also waits on adv so a pending last byte is never overwritten by the next line's first select
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rd_addr   <= '0;
      buf_sel   <= 1'b0;
      out_valid <= 1'b0;
      buf_done1 <= 1'b0;
      buf_done2 <= 1'b0;
    end else begin
      buf_done1 <= 1'b0;
      buf_done2 <= 1'b0;
      if (adv) out_valid <= |sel;
      case (state)
        IDLE: if (start) state <= WAIT_BUF;
        WAIT_BUF: if (adv && full) begin
          state   <= SEND_R;
          sel     <= 3'b001;
          rd_addr <= '0;
        end
        SEND_R: if (adv) begin
          state <= SEND_G;
          sel   <= 3'b010;
        end
        SEND_G: if (adv) begin
          state <= SEND_B;
          sel   <= 3'b100;
        end
        SEND_B: if (adv) begin
          if (rd_addr == LAST) begin
            state     <= start ? WAIT_BUF : IDLE;
            sel       <= '0;
            rd_addr   <= '0;
            buf_sel   <= ~buf_sel;
            buf_done1 <= ~buf_sel;
            buf_done2 <= buf_sel;
          end else begin
            state   <= SEND_R;
            sel     <= 3'b001;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_buf_mux_sequencer.sv
// tb_buf_mux_sequencer: scoreboarded bench for the ping-pong RGB mux sequencer
module tb_buf_mux_sequencer;
  localparam int AW = 8;
  localparam int N  = 4;
  logic clk = 1'b0;
  logic rst, start, full1, full2, ready;
  logic [AW-1:0] rd_addr;
  logic sr1, sg1, sb1, sr2, sg2, sb2, buf_sel, out_valid, done1, done2, busy;
  int tests = 0, fails = 0;
  int exp_q[$];
  int exp_buf = 0, e_done1 = 0, e_done2 = 0, n_done1 = 0, n_done2 = 0;
  int pres = 0, cyc = 0, run = 0, max_run = 0, nval = 0, first_v = -1, last_v = -1;
  bit pres_v = 1'b0, rnd = 1'b0;

  always #5 clk = ~clk;

  buf_mux_sequencer #(.ADDR_W(AW), .LINE_PIXELS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .buf_full1(full1), .buf_full2(full2),
    .out_ready(ready), .rd_addr(rd_addr),
    .sel_r1(sr1), .sel_g1(sg1), .sel_b1(sb1), .sel_r2(sr2), .sel_g2(sg2), .sel_b2(sb2),
    .buf_sel(buf_sel), .out_valid(out_valid), .buf_done1(done1), .buf_done2(done2), .busy(busy)
  );

  // expected downstream bytes of one whole line: buffer*1000 + pixel*4 + colour (R=0,G=1,B=2)
  task automatic push_line();
    for (int p = 0; p < N; p++)
      for (int c = 0; c < 3; c++) exp_q.push_back(exp_buf * 1000 + p * 4 + c);
    if (exp_buf == 0) e_done1++; else e_done2++;
    exp_buf = 1 - exp_buf;
  endtask

  // one clock: check invariants, emulate the registered byte mux, score accepted bytes, advance
  task automatic tick();
    logic [2:0] s1, s2;
    int id;
    if (rnd) begin
      ready = ($urandom_range(0, 3) != 0);
      full1 = 1'($urandom_range(0, 1));
      full2 = 1'($urandom_range(0, 1));
    end
    s1 = {sb1, sg1, sr1};
    s2 = {sb2, sg2, sr2};
    id = (s2 != 0 ? 1000 : 0) + int'(rd_addr) * 4 + ((s1[0] | s2[0]) ? 0 : (s1[1] | s2[1]) ? 1 : 2);
    tests++;
    if ($countones({s1, s2}) > 1 || (buf_sel ? s1 : s2) != 0) begin
      fails++;
      $display("FAIL sel_onehot: sel1=%b sel2=%b buf_sel=%b, required at most one select on active buffer", s1, s2, buf_sel);
    end
    tests++;
    if (int'(rd_addr) >= N) begin
      fails++;
      $display("FAIL addr_bound: rd_addr=%0d, required < %0d", rd_addr, N);
    end
    tests++;
    if (out_valid !== pres_v) begin
      fails++;
      $display("FAIL out_valid: got %b, required %b", out_valid, pres_v);
    end
    tests++;
    if (done1 && done2) begin
      fails++;
      $display("FAIL done_excl: done1=%b done2=%b, required not both", done1, done2);
    end
    if (done1) n_done1++;
    if (done2) n_done2++;
    if (out_valid) begin
      nval++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (out_valid && ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_byte: got %0d, required no byte", pres);
      end else begin
        if (pres != exp_q[0]) begin
          fails++;
          $display("FAIL byte: got %0d, required %0d", pres, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (!out_valid || ready) begin
      pres_v = (s1 | s2) != 0;
      pres   = id;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < budget) begin
      tick();
      i++;
    end
    tests++;
    if (exp_q.size() != 0 || out_valid) begin
      fails++;
      $display("FAIL drain: %0d bytes left, out_valid=%b, required 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic check_done(input string name);
    tests++;
    if (n_done1 != e_done1 || n_done2 != e_done2) begin
      fails++;
      $display("FAIL %s done_count: got %0d/%0d, required %0d/%0d", name, n_done1, n_done2, e_done1, e_done2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; full1 = 1'b0; full2 = 1'b0; ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({rd_addr, sr1, sg1, sb1, sr2, sg2, sb2, buf_sel, out_valid, done1, done2, busy} !== '0) begin
      fails++;
      $display("FAIL reset: outputs=%b, required all 0", {rd_addr, sr1, sg1, sb1, sr2, sg2, sb2, buf_sel, out_valid, done1, done2, busy});
    end
  endtask

  task automatic test_single_line();
    start = 1'b1; full1 = 1'b1; full2 = 1'b0; ready = 1'b1; max_run = 0;
    push_line();
    tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wait_busy: got %b, required 1", busy); end
    tick();
    tests++;
    if (sr1 !== 1'b1 || rd_addr !== 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_sel: sel_r1=%b addr=%0d valid=%b, required 1 0 0", sr1, rd_addr, out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b, required 1", out_valid); end
    drain(40);
    tests++;
    if (max_run != 3 * N) begin fails++; $display("FAIL valid_run: got %0d, required %0d", max_run, 3 * N); end
    check_done("line1");
    tests++;
    if (buf_sel !== 1'b1) begin fails++; $display("FAIL buf_swap: got %b, required 1", buf_sel); end
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || {sr1, sg1, sb1, sr2, sg2, sb2} !== '0) begin
      fails++;
      $display("FAIL wait_hold: busy=%b valid=%b sels=%b, required 1 0 0", busy, out_valid, {sr1, sg1, sb1, sr2, sg2, sb2});
    end
    full1 = 1'b0; full2 = 1'b1;
    push_line();
    drain(60);
    check_done("line2");
    tests++;
    if (buf_sel !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL line2_end: buf_sel=%b busy=%b, required 0 1", buf_sel, busy);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    full1 = 1'b1; full2 = 1'b1; nval = 0; first_v = -1;
    push_line();
    push_line();
    while (buf_sel !== 1'b1 && i < 50) begin tick(); i++; end
    start = 1'b0;
    drain(60);
    tests++;
    if (nval != 6 * N || last_v - first_v != 6 * N) begin
      fails++;
      $display("FAIL back_to_back: valid=%0d span=%0d, required %0d %0d", nval, last_v - first_v, 6 * N, 6 * N);
    end
    check_done("b2b");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_start_drop();
    int i = 0;
    start = 1'b1; full1 = 1'b1; full2 = 1'b0;
    push_line();
    while (!(rd_addr == 1 && sr1) && i < 30) begin tick(); i++; end
    start = 1'b0;
    drain(40);
    for (int k = 0; k < 3; k++) tick();
    check_done("start_drop");
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL start_drop_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_stall();
    int i = 0;
    start = 1'b1; full1 = 1'b0; full2 = 1'b1;
    push_line();
    while (!(rd_addr == 2 && sg2) && i < 30) begin tick(); i++; end
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (sg2 !== 1'b1 || rd_addr !== 2 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: sel_g2=%b addr=%0d valid=%b, required 1 2 1", sg2, rd_addr, out_valid);
      end
    end
    ready = 1'b1; start = 1'b0;
    drain(40);
    check_done("stall");
  endtask

  task automatic test_random();
    int i = 0;
    int base;
    base = n_done1 + n_done2;
    start = 1'b1;
    for (int k = 0; k < 4; k++) push_line();
    rnd = 1'b1;
    while (n_done1 + n_done2 < base + 3 && i < 600) begin tick(); i++; end
    start = 1'b0;
    drain(600);
    rnd = 1'b0; ready = 1'b1;
    check_done("random");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL random_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    start = 1'b1; full1 = 1'b1; full2 = 1'b0; ready = 1'b1;
    push_line();
    while (!(rd_addr == 3 && sg1) && i < 30) begin tick(); i++; end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rd_addr, sr1, sg1, sb1, sr2, sg2, sb2, buf_sel, out_valid, done1, done2, busy} !== '0) begin
      fails++;
      $display("FAIL async_reset: outputs=%b, required all 0", {rd_addr, sr1, sg1, sb1, sr2, sg2, sb2, buf_sel, out_valid, done1, done2, busy});
    end
    exp_q.delete();
    pres_v = 1'b0; exp_buf = 0; e_done1--;
    tick();
    tick();
    rst = 1'b0;
    push_line();
    i = 0;
    while ({sr1, sg1, sb1, sr2, sg2, sb2} == 0 && i < 10) begin tick(); i++; end
    tests++;
    if (sr1 !== 1'b1 || rd_addr !== 0) begin
      fails++;
      $display("FAIL restart: sel_r1=%b addr=%0d, required 1 0", sr1, rd_addr);
    end
    start = 1'b0;
    drain(40);
    check_done("reset_mid");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; full1 = 1'b0; full2 = 1'b0; ready = 1'b1;
    #1;
    test_reset();
    test_single_line();
    test_back_to_back();
    test_start_drop();
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
